// File: rtl/tinyalu.sv
// Sequenced 8-bit ALU: 1-cycle add/and/xor, 3-cycle multiply, one-cycle done pulse.
// Optional subtract on op=5 is built only when TINYALU_SUB_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; 1-cycle ops complete directly from here
// MUL1  | operands captured, first multiply cycle
// MUL2  | product registered into result on leaving this state
module tinyalu (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] result_next;
    logic        done_next;
    logic        capture;
    logic [8:0]  sum9;
    logic [15:0] product;

    assign sum9    = {1'b0, A} + {1'b0, B};
    assign product = {8'b0, a_q} * {8'b0, b_q};

    always_comb begin
        state_next  = state;
        result_next = result;
        done_next   = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                // Inputs are only looked at when start is high in IDLE.
                if (start) begin
                    case (op)
                        3'd1: begin
                            result_next = {7'b0, sum9};
                            done_next   = 1'b1;
                        end
                        3'd2: begin
                            result_next = {8'b0, A & B};
                            done_next   = 1'b1;
                        end
                        3'd3: begin
                            result_next = {8'b0, A ^ B};
                            done_next   = 1'b1;
                        end
                        3'd4: begin
                            capture    = 1'b1;
                            state_next = MUL1;
                        end
`ifdef TINYALU_SUB_EN
                        3'd5: begin
                            result_next = {8'b0, A} - {8'b0, B};
                            done_next   = 1'b1;
                        end
`endif
                        3'd7: begin
                            result_next = 16'h0000;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            MUL1: begin
                state_next = MUL2;
            end
            MUL2: begin
                result_next = product;
                done_next   = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // reset_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state  <= IDLE;
            result <= 16'h0000;
            done   <= 1'b0;
            a_q    <= 8'h00;
            b_q    <= 8'h00;
        end else begin
            state  <= state_next;
            result <= result_next;
            done   <= done_next;
            if (capture) begin
                a_q <= A;
                b_q <= B;
            end
        end
    end

endmodule

// File: tb/tb_tinyalu.sv
// Directed vector bench for tinyalu: per-cycle table plus a reset-during-multiply sequence.
module tb_tinyalu;

    logic        clk;
    logic        reset_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;

    int vectors;
    int miscompares;

    typedef struct {
        string       name;
        logic        start;
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        exp_done;
        logic [15:0] exp_result;
    } vec_t;

    vec_t vecs[$];

    tinyalu dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .op      (op),
        .start   (start),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic exp_done, input logic [15:0] exp_result);
        vectors++;
        if (done !== exp_done || result !== exp_result) begin
            miscompares++;
            $display("FAIL %s: got done=%b result=%h, expected done=%b result=%h",
                     name, done, result, exp_done, exp_result);
        end
    endtask

    initial begin
        logic [15:0] held;
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b1;
        start       = 1'b0;
        op          = 3'd0;
        A           = 8'h00;
        B           = 8'h00;

        repeat (2) @(posedge clk);
        #1 check("reset_held", 1'b0, 16'h0000);
        @(negedge clk) reset_n = 1'b0;
        @(posedge clk);
        #1 check("reset_release", 1'b0, 16'h0000);

        // Each row: inputs held for one edge, outputs expected just after that edge.
        vecs.push_back('{"idle",          1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000});
        vecs.push_back('{"add_ff_01",     1'b1, 3'd1, 8'hFF, 8'h01, 1'b1, 16'h0100});
        vecs.push_back('{"add_hold",      1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0100});
        vecs.push_back('{"no_op",         1'b1, 3'd0, 8'h12, 8'h34, 1'b0, 16'h0100});
        vecs.push_back('{"rst_op",        1'b1, 3'd7, 8'h12, 8'h34, 1'b0, 16'h0000});
        vecs.push_back('{"and_f0_3c",     1'b1, 3'd2, 8'hF0, 8'h3C, 1'b1, 16'h0030});
        vecs.push_back('{"xor_b2b",       1'b1, 3'd3, 8'hF0, 8'h3C, 1'b1, 16'h00CC});
        vecs.push_back('{"xor_hold",      1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h00CC});
        vecs.push_back('{"mul_n",         1'b1, 3'd4, 8'hFF, 8'hFF, 1'b0, 16'h00CC});
        vecs.push_back('{"mul_n1_x",      1'b1, 3'd4, 8'hxx, 8'hxx, 1'b0, 16'h00CC});
        vecs.push_back('{"mul_n2_done",   1'b1, 3'd4, 8'h02, 8'h03, 1'b1, 16'hFE01});
        vecs.push_back('{"mul2_accept",   1'b1, 3'd4, 8'h02, 8'h03, 1'b0, 16'hFE01});
        vecs.push_back('{"mul2_busy_add", 1'b1, 3'd1, 8'h11, 8'h11, 1'b0, 16'hFE01});
        vecs.push_back('{"mul2_done",     1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 16'h0006});
        vecs.push_back('{"add_after_mul", 1'b1, 3'd1, 8'h10, 8'h20, 1'b1, 16'h0030});
        vecs.push_back('{"op6_unused",    1'b1, 3'd6, 8'h55, 8'hAA, 1'b0, 16'h0030});
`ifdef TINYALU_SUB_EN
        vecs.push_back('{"sub_01_02",     1'b1, 3'd5, 8'h01, 8'h02, 1'b1, 16'hFFFF});
`else
        vecs.push_back('{"sub_disabled",  1'b1, 3'd5, 8'h01, 8'h02, 1'b0, 16'h0030});
`endif
        vecs.push_back('{"add_carry",     1'b1, 3'd1, 8'h80, 8'h80, 1'b1, 16'h0100});
        vecs.push_back('{"x_idle",        1'b0, 3'bxxx, 8'hxx, 8'hxx, 1'b0, 16'h0100});
        vecs.push_back('{"add_zero",      1'b1, 3'd1, 8'h00, 8'h00, 1'b1, 16'h0000});
        vecs.push_back('{"mul_small",     1'b1, 3'd4, 8'h10, 8'h10, 1'b0, 16'h0000});
        vecs.push_back('{"mul_small_1",   1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0000});
        vecs.push_back('{"mul_small_2",   1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 16'h0100});
        vecs.push_back('{"mul_small_3",   1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 16'h0100});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start = vecs[i].start;
            op    = vecs[i].op;
            A     = vecs[i].a;
            B     = vecs[i].b;
            @(posedge clk);
            #1 check(vecs[i].name, vecs[i].exp_done, vecs[i].exp_result);
        end
        held = vecs[vecs.size() - 1].exp_result;

        // Reset arriving at N+1 of a multiply aborts it with no done.
        @(negedge clk);
        start = 1'b1; op = 3'd4; A = 8'h03; B = 8'h04;
        @(posedge clk);
        #1 check("abort_accept", 1'b0, held);
        @(negedge clk);
        start = 1'b0; op = 3'd0; reset_n = 1'b1;
        @(posedge clk);
        #1 check("abort_reset", 1'b0, 16'h0000);
        @(negedge clk) reset_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 check("abort_after", 1'b0, 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
